// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if -- bus bundle between the instruction cache, the datapath fetch
// stage and the backing memory.
//
// Datapath side (request/response):
//   imemREN   datapath -> cache  fetch request for imemaddr
//   imemaddr  datapath -> cache  byte address of the wanted instruction
//   iflush    datapath -> cache  invalidate every frame
//   ihit      cache -> datapath  imemload is valid for imemaddr this cycle
//   imemload  cache -> datapath  instruction word (0 when ihit=0)
//
// Memory side (read channel):
//   iREN      cache -> memory    read request, held until accepted
//   iaddr     cache -> memory    word-aligned byte address, stable while iREN=1
//   iwait     memory -> cache    memory busy
//   iload     memory -> cache    read data
//
// Handshake semantics: a datapath request is "valid" while imemREN=1 and
// completes on the cycle ihit=1; the datapath keeps imemREN/imemaddr up until
// then (it may also redirect them). A memory read is "valid" while iREN=1 and
// is accepted on the single cycle where iREN=1 and iwait=0; iload is sampled
// at the end of exactly that cycle. iaddr never changes while iREN=1.
//
// Modports: slave = the cache, master = whatever drives the cache
// (datapath plus memory model).
// ---------------------------------------------------------------------------
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache -- direct-mapped instruction cache, one 32-bit word per frame.
//
// Address split: [1:0] byte offset (ignored), [IW+1:2] frame index,
// [31:IW+2] tag. A hit is reported combinationally in the cycle of the
// request; a miss moves the controller to FILL, where it reads the word from
// memory and allocates the frame. There is no forwarding: the word becomes
// visible as a hit on the cycle after the fill completes.
//
// Ports:
//   CLK         sole clock, rising edge
//   RST         synchronous active-high reset
//   bus         icache_if.slave (datapath request/response + memory read)
//   hit_count   number of hits since reset, wraps at 2^32
//   miss_count  number of misses since reset, wraps at 2^32
//   o_state     controller state for observation (0 = IDLE, 1 = FILL)
// ---------------------------------------------------------------------------
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic        o_state
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Controller state and registered outputs.
  state_t         r_state;
  logic           r_iren;
  logic [31:2]    r_miss_word;   // miss address, byte offset dropped
  logic [31:0]    r_hit_count;
  logic [31:0]    r_miss_count;

  // Frame storage. Only the valid bits are reset; tag and data are
  // meaningless while their valid bit is clear.
  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS];

  // Request decode.
  logic [IW-1:0]  w_idx;
  logic [TW-1:0]  w_tag;
  logic           w_frame_match;
  logic           w_req;
  logic           w_hit;
  logic           w_miss;

  // Fill decode.
  logic [IW-1:0]  w_fill_idx;
  logic [TW-1:0]  w_fill_tag;
  logic           w_fill_done;

  assign w_idx         = bus.imemaddr[IW+1:2];
  assign w_tag         = bus.imemaddr[31:IW+2];
  assign w_frame_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A request is only evaluated in IDLE, outside reset, and not in a flush
  // cycle: the flush both hides the hit and suppresses miss accounting.
  assign w_req  = !RST && (r_state == IDLE) && bus.imemREN && !bus.iflush;
  assign w_hit  = w_req && w_frame_match;
  assign w_miss = w_req && !w_frame_match;

  assign w_fill_idx  = r_miss_word[IW+1:2];
  assign w_fill_tag  = r_miss_word[31:IW+2];
  // Memory accepts the read: iREN high (i.e. FILL) and not busy.
  assign w_fill_done = !RST && (r_state == FILL) && !bus.iwait;

  // Datapath outputs. imemload is forced to zero whenever there is no hit.
  assign bus.ihit     = w_hit;
  assign bus.imemload = w_hit ? r_data[w_idx] : 32'h0;

  // Memory outputs. r_iren is high exactly in FILL; RST masks it in the
  // reset cycle itself so nothing is requested while reset is held.
  assign bus.iREN  = r_iren && !RST;
  assign bus.iaddr = (r_iren && !RST) ? {r_miss_word, 2'b00} : 32'h0;

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign o_state    = r_state;

  // -------------------------------------------------------------------------
  // Controller: state, registered memory request, miss address, counters
  // and valid bits.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_iren       <= 1'b0;
      r_miss_word  <= '0;
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
      r_valid      <= '0;
    end else begin
      // Flush clears everything first; a fill completing in the same cycle
      // re-validates its own frame below (later assignment wins for that bit).
      if (bus.iflush) begin
        r_valid <= '0;
      end

      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_hit_count <= r_hit_count + 32'd1;
          end else if (w_miss) begin
            r_miss_word  <= bus.imemaddr[31:2];
            r_miss_count <= r_miss_count + 32'd1;
            r_iren       <= 1'b1;
            r_state      <= FILL;
          end
        end

        FILL: begin
          // The fill runs to completion for the latched address regardless
          // of what the datapath does with imemREN/imemaddr meanwhile.
          if (!bus.iwait) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_iren              <= 1'b0;
            r_state             <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_iren  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tag/data arrays: written only when a fill is accepted. A conflicting
  // index simply overwrites the previous occupant.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.iload;
    end
  end

endmodule
